// File: rtl/dig_scan_ctrl.sv
// Multiplexed digit scanner: walks slots NDIG-1..0 with a blanking lead-in per slot.
// Codes and enables are shadowed once per frame, so the display only changes between frames.
module dig_scan_ctrl #(
  parameter int NDIG  = 4,
  parameter int NW    = 5,
  parameter int DWELL = 1024,
  parameter int BLANK = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NDIG*NW-1:0]   num_in,
  input  logic [NDIG-1:0]      enb,
  input  logic                 skip,
  output logic [NDIG-1:0]      DIG,
  output logic [NW-1:0]        num,
  output logic                 frame_done
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [CW-1:0] CNT_MAX  = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_C  = CW'(BLANK);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

  logic [IW-1:0]      idx, idx_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [NDIG*NW-1:0] sh_num, sh_num_n;
  logic [NDIG-1:0]    sh_enb, sh_enb_n;
  logic               skip_q;

  logic               slot_en, slot_last, frame_end;
  logic               en_n, lit_n, fd_n;
  logic [NDIG-1:0]    dig_n;
  logic [NW-1:0]      num_n;

  // skip is registered so the slot-length decision made next cycle uses the
  // same skip value that predicted frame_done for that cycle.
  always_comb begin
    slot_en   = sh_enb[idx];
    slot_last = (slot_en || !skip_q) ? (cnt == CNT_MAX) : 1'b1;
    frame_end = slot_last && (idx == '0);

    idx_n    = idx;
    cnt_n    = cnt + 1'b1;
    sh_num_n = sh_num;
    sh_enb_n = sh_enb;

    if (slot_last) begin
      cnt_n = '0;
      idx_n = (idx == '0) ? IDX_LAST : idx - 1'b1;
    end
    if (frame_end) begin
      sh_num_n = num_in;
      sh_enb_n = enb;
    end

    // Outputs are registered from the next state so they line up with (idx, cnt).
    en_n  = sh_enb_n[idx_n];
    lit_n = en_n && (cnt_n >= BLANK_C);
    dig_n = '1;
    if (lit_n) dig_n[idx_n] = 1'b0;
    num_n = lit_n ? sh_num_n[idx_n*NW +: NW] : '0;
    fd_n  = (idx_n == '0) && ((en_n || !skip) ? (cnt_n == CNT_MAX) : 1'b1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx        <= IDX_LAST;
      cnt        <= '0;
      sh_num     <= '0;
      sh_enb     <= '0;
      skip_q     <= 1'b0;
      DIG        <= '1;
      num        <= '0;
      frame_done <= 1'b0;
    end else begin
      idx        <= idx_n;
      cnt        <= cnt_n;
      sh_num     <= sh_num_n;
      sh_enb     <= sh_enb_n;
      skip_q     <= skip;
      DIG        <= dig_n;
      num        <= num_n;
      frame_done <= fd_n;
    end
  end

endmodule

// File: doc/dig_scan_ctrl.md
DIG_SCAN_CTRL -- requirements
Module: dig_scan_ctrl

Interface
REQ-001 The block SHALL have parameter NDIG, default 4, giving the number of digits scanned; legal values are 2 to 16.
REQ-002 The block SHALL have parameter NW, default 5, giving the width of each digit code.
REQ-003 The block SHALL have parameter DWELL, default 1024, giving clocks per enabled digit slot; legal values are 2 or more.
REQ-004 The block SHALL have parameter BLANK, default 16, giving dark clocks at the start of each slot; BLANK SHALL satisfy 1 <= BLANK < DWELL.
REQ-005 clk  in  1  -- single clock; all state changes on the rising edge.
REQ-006 rst_n  in  1  -- reset, synchronous and active-low.
REQ-007 num_in  in  NDIG*NW  -- digit i code at bits [i*NW +: NW].
REQ-008 enb  in  NDIG  -- enb[i]=1 means digit i is lit.
REQ-009 skip  in  1  -- 1 means a disabled slot is shortened to 1 clock; 0 means a disabled slot is held dark for the full DWELL.
REQ-010 DIG  out  NDIG  -- active-low digit select, at most one bit low.
REQ-011 num  out  NW  -- code of the currently selected digit.
REQ-012 frame_done  out  1  -- single-cycle pulse in the last cycle of each frame.

Function
REQ-013 The block SHALL hold a slot index idx, a dwell counter cnt (0..DWELL-1) and shadow copies of num_in and enb.
REQ-014 A frame SHALL visit slots NDIG-1, NDIG-2, ... 0 in that order, then wrap to NDIG-1; this order is fixed regardless of enables.
REQ-015 An enabled slot, or a disabled slot with skip=0, SHALL last exactly DWELL clocks (cnt 0..DWELL-1).
REQ-016 A disabled slot with skip=1 SHALL last exactly 1 clock (cnt=0 only).
REQ-017 Enable and code decisions SHALL use shadow values only, never the live inputs.
REQ-018 When cnt<BLANK or the slot is disabled, DIG SHALL be all ones.
REQ-019 When cnt>=BLANK and the slot is enabled, DIG SHALL equal all ones except bit idx low.
REQ-020 num SHALL equal the shadow code of slot idx whenever DIG has a bit low, and 0 otherwise.
REQ-021 DIG, num and frame_done SHALL be driven directly from flip-flops, with no combinational path from any input to any output.
REQ-022 The outputs SHALL reflect the current (idx, cnt) in the same cycle, i.e. they are computed from next-state.
REQ-023 In the final cycle of slot 0, frame_done SHALL be 1, both shadows SHALL load from num_in and enb, and idx SHALL wrap to NDIG-1 with cnt=0.
REQ-024 Input changes mid-frame SHALL NOT alter the display until the next frame (frame-coherent update).
REQ-025 With skip=1 and all shadow enables 0, a frame SHALL last NDIG clocks with DIG all ones and frame_done asserted every NDIG clocks.
REQ-026 Frame length SHALL be E*DWELL + (NDIG-E)*(skip ? 1 : DWELL) clocks, where E is the number of enabled slots in the shadow.
REQ-027 The cnt width SHALL be ceil(log2(DWELL)) bits; cnt SHALL NOT overflow or wrap anywhere other than at a slot end.

Reset
REQ-028 While rst_n=0 at a clock edge, the block SHALL set idx=NDIG-1, cnt=0, shadow codes=0, shadow enables=0, DIG=all ones, num=0 and frame_done=0.
REQ-029 Reset asserted mid-slot or mid-frame SHALL take effect at the next edge, with no partial-slot completion.
REQ-030 Because the shadow enables are 0, the first frame after reset SHALL be fully dark; live values SHALL appear from the second frame onward.

Verification (NDIG=4, NW=5, DWELL=8, BLANK=2)
REQ-031 Reset test: hold rst_n=0 for 3 clocks, then release with skip=0 -> DIG=4'b1111 and num=0 throughout; the first frame is dark for 32 clocks; frame_done pulses at clock 31.
REQ-032 Scan test: set enb=4'b1111 and digit codes 3,2,1,0 for digits 3..0 -> in the second frame, clocks 0-1 give DIG=1111; clocks 2-7 give DIG=0111 with num=3; then 1011 with num=2, 1101 with num=1, 1110 with num=0, each for 6 clocks after 2 blank clocks; frame_done at frame clock 31.
REQ-033 Coherence test: change digit 1 code from 1 to 9 at frame clock 10 -> digit 1 still shows 1 in that frame and shows 9 in the following frame.
REQ-034 Skip test: set skip=1, enb=4'b0101 -> frame length is 18 clocks; digits 3 and 1 are each dark for 1 clock; frame_done period is 18.
REQ-035 Empty test: set skip=1, enb=4'b0000 -> DIG stays 1111 and num stays 0; frame_done period is 4.
REQ-036 Mid-op reset test: assert rst_n=0 at cnt=5 of slot 2 -> at the next edge idx=3, cnt=0, DIG=1111, num=0; no frame_done pulse occurs.
